// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared types and constants for the tx AXIS frame arbiter
package tx_arb_pkg;

    localparam int AXIS_DATA_W       = 64;
    localparam int AXIS_KEEP_W       = 8;
    localparam int DEFAULT_MAX_BEATS = 1200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - single-stage AXIS register slice (data/keep/last/user)
module axis_reg_slice
    import tx_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXIS_DATA_W-1:0] s_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tuser,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [AXIS_DATA_W-1:0] m_tdata,
    output logic [AXIS_KEEP_W-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tuser,
    output logic                   m_tvalid,
    input  logic                   m_tready
);

    // The slice can take a beat when it is empty or its beat leaves this cycle.
    assign s_tready = ~m_tvalid | m_tready;

    // Load a new beat on acceptance; hold everything stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
                m_tkeep <= s_tkeep;
                m_tlast <= s_tlast;
                m_tuser <= s_tuser;
            end
        end
    end

endmodule

// File: rtl/tx_axis_arbiter.sv
// rtl/tx_axis_arbiter.sv - frame-level 2:1 AXIS arbiter for tx MAC; option TX_ARB_STRICT_PRIO_EN
module tx_axis_arbiter
    import tx_arb_pkg::*;
#(
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_pause_active,
    input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s0_axis_tkeep,
    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic                   s0_axis_tlast,
    input  logic                   s0_axis_tuser,
    input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s1_axis_tkeep,
    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic                   s1_axis_tlast,
    input  logic                   s1_axis_tuser,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [1:0]             grant,
    output logic [CNT_W-1:0]       frame_cnt0,
    output logic [CNT_W-1:0]       frame_cnt1,
    output logic [15:0]            trunc_cnt
);

    localparam int               BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    arb_state_t              state;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [1:0]              pick;

`ifndef TX_ARB_STRICT_PRIO_EN
    logic                    rr_ptr;
`endif

    logic                    owner;
    logic [AXIS_DATA_W-1:0]  own_tdata;
    logic [AXIS_KEEP_W-1:0]  own_tkeep;
    logic                    own_tvalid;
    logic                    own_tlast;
    logic                    own_tuser;
    logic                    own_tready;
    logic                    slice_ready;
    logic                    acc;
    logic                    at_limit;
    logic                    trunc;
    logic                    sl_valid;

    // grant is one-hot, so bit 1 alone selects the owning port.
    assign owner      = grant[1];
    assign own_tdata  = owner ? s1_axis_tdata  : s0_axis_tdata;
    assign own_tkeep  = owner ? s1_axis_tkeep  : s0_axis_tkeep;
    assign own_tvalid = owner ? s1_axis_tvalid : s0_axis_tvalid;
    assign own_tlast  = owner ? s1_axis_tlast  : s0_axis_tlast;
    assign own_tuser  = owner ? s1_axis_tuser  : s0_axis_tuser;

    // While draining a truncated frame the owner is always accepted and discarded.
    assign own_tready     = ((state == XFER) & slice_ready) | (state == DRAIN);
    assign s0_axis_tready = grant[0] & own_tready;
    assign s1_axis_tready = grant[1] & own_tready;

    assign acc      = (|grant) & own_tvalid & own_tready;
    assign at_limit = (beat_cnt == LAST_BEAT);
    assign trunc    = at_limit & ~own_tlast;
    assign sl_valid = (state == XFER) & (|grant) & own_tvalid;

    axis_reg_slice u_slice (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (own_tdata),
        .s_tkeep  (own_tkeep),
        .s_tlast  (own_tlast | trunc),
        .s_tuser  (own_tuser | trunc),
        .s_tvalid (sl_valid),
        .s_tready (slice_ready),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tlast  (m_axis_tlast),
        .m_tuser  (m_axis_tuser),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

    // Choose the next owner among the requesting ports.
    always_comb begin
        pick = 2'b00;
`ifdef TX_ARB_STRICT_PRIO_EN
        pick = s0_axis_tvalid ? 2'b01 : 2'b10;
`else
        if (s0_axis_tvalid && s1_axis_tvalid) begin
            pick = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            pick = s0_axis_tvalid ? 2'b01 : 2'b10;
        end
`endif
    end

    // Frame arbitration, beat counting, truncation and per-port statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            beat_cnt   <= '0;
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
            trunc_cnt  <= '0;
`ifndef TX_ARB_STRICT_PRIO_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (!rx_pause_active && (s0_axis_tvalid || s1_axis_tvalid)) begin
                        grant <= pick;
                        state <= XFER;
`ifndef TX_ARB_STRICT_PRIO_EN
                        if (s0_axis_tvalid && s1_axis_tvalid) begin
                            rr_ptr <= ~rr_ptr;
                        end
`endif
                    end
                end
                XFER: begin
                    if (acc) begin
                        if (own_tlast) begin
                            grant <= 2'b00;
                            state <= IDLE;
                            if (owner) begin
                                frame_cnt1 <= frame_cnt1 + 1'b1;
                            end else begin
                                frame_cnt0 <= frame_cnt0 + 1'b1;
                            end
                        end else if (at_limit) begin
                            state <= DRAIN;
                            if (trunc_cnt != 16'hFFFF) begin
                                trunc_cnt <= trunc_cnt + 16'd1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (acc && own_tlast) begin
                        grant <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
